// File: rtl/mem_pkg.sv
// Shared types and constants for the 6502 bus-side memory responder.
package mem_pkg;

    localparam int CNT_W = 4;

    localparam logic [15:0] VEC_RESET_LO = 16'hFFFC;
    localparam logic [15:0] VEC_RESET_HI = 16'hFFFD;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    function automatic logic is_vector(input logic [15:0] a);
        return (a == VEC_RESET_LO) || (a == VEC_RESET_HI);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port byte RAM: synchronous write, combinational read, no reset.
module mem_array #(
    parameter int AW = 12
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Bus-side memory responder: latches a CPU request, stalls via rdy for
// WAIT_STATES cycles, then reads/writes RAM or returns the reset vector.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          MEM_AW      = 12,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] RESET_VEC   = 16'h0200
) (
    input  logic        ph2,
    input  logic        reset_b,
    input  logic        mem_req,
    input  logic        rw,
    input  logic [15:0] address,
    input  logic [7:0]  data_out,
    output logic [7:0]  data_in,
    output logic        rdy
);

    localparam logic ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_in_q, data_in_d;

    logic [15:0] addr_q;
    logic        rw_q;
    logic [7:0]  wdata_q;

    logic        accept, acc_en, acc_rw, ram_we;
    logic [15:0] acc_addr;
    logic [7:0]  acc_wdata, ram_rdata;

    assign accept = (state_q == IDLE) && mem_req;

    // With no wait states the access happens on the accept edge itself,
    // so it must use the live bus rather than the latched copy.
    assign acc_addr  = ZERO_WAIT ? address  : addr_q;
    assign acc_rw    = ZERO_WAIT ? rw       : rw_q;
    assign acc_wdata = ZERO_WAIT ? data_out : wdata_q;
    assign acc_en    = ZERO_WAIT ? accept : ((state_q == WAIT) && (cnt_q == '0));

    assign ram_we = reset_b && acc_en && !acc_rw && !is_vector(acc_addr);

    mem_array #(
        .AW(MEM_AW)
    ) u_array (
        .clk_i   (ph2),
        .we_i    (ram_we),
        .addr_i  (acc_addr[MEM_AW-1:0]),
        .wdata_i (acc_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_in_d = data_in_q;
        case (state_q)
            IDLE: begin
                if (accept && !ZERO_WAIT) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (acc_en && acc_rw) begin
            if (acc_addr == VEC_RESET_LO) begin
                data_in_d = RESET_VEC[7:0];
            end else if (acc_addr == VEC_RESET_HI) begin
                data_in_d = RESET_VEC[15:8];
            end else begin
                data_in_d = ram_rdata;
            end
        end
    end

    always_ff @(posedge ph2 or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_in_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_in_q <= data_in_d;
        end
    end

    // Request latches carry data only; they are qualified by state, not reset.
    always_ff @(posedge ph2) begin
        if (accept) begin
            addr_q  <= address;
            rw_q    <= rw;
            wdata_q <= data_out;
        end
    end

    assign data_in = data_in_q;
    assign rdy     = (state_q == IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances with 0..3 wait states, table vectors,
// directed corner sequences and randomized traffic against a byte-array model.
module tb_mem_responder;

    localparam logic [7:0] RV_LO = 8'h00;
    localparam logic [7:0] RV_HI = 8'h02;

    logic        ph2;
    logic        rst_b  [4];
    logic        req    [4];
    logic        rw_s   [4];
    logic [15:0] addr   [4];
    logic [7:0]  wd     [4];
    logic [7:0]  rd     [4];
    logic        rdy_s  [4];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mdl  [4][4096];
    logic [7:0] last [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_responder #(
            .MEM_AW      (12),
            .WAIT_STATES (g),
            .RESET_VEC   (16'h0200)
        ) u_dut (
            .ph2      (ph2),
            .reset_b  (rst_b[g]),
            .mem_req  (req[g]),
            .rw       (rw_s[g]),
            .address  (addr[g]),
            .data_out (wd[g]),
            .data_in  (rd[g]),
            .rdy      (rdy_s[g])
        );
    end

    initial ph2 = 1'b0;
    always #5 ph2 = ~ph2;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    typedef struct {
        logic        r;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (W=%0d): got %h expected %h", name, inst, act, exp);
        end
    endtask

    // Reference model: byte array per instance plus the last value read.
    function automatic logic [7:0] mdl_access(input int i, input logic r, input logic [15:0] a,
                                              input logic [7:0] d);
        if (r) begin
            if (a == 16'hFFFC)      last[i] = RV_LO;
            else if (a == 16'hFFFD) last[i] = RV_HI;
            else                    last[i] = mdl[i][a % 4096];
        end else if (a != 16'hFFFC && a != 16'hFFFD) begin
            mdl[i][a % 4096] = d;
        end
        return last[i];
    endfunction

    // One bus access on instance i (wait states = i). Inputs are scrambled
    // while stalled so any use of the live bus shows up as a data error.
    task automatic access(input int i, input logic r, input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] q);
        @(negedge ph2);
        req[i]  = 1'b1;
        rw_s[i] = r;
        addr[i] = a;
        wd[i]   = d;
        @(posedge ph2);
        #1;
        req[i] = 1'b0;
        if (i > 0) begin
            req[i]  = 1'($urandom);
            rw_s[i] = 1'($urandom);
            addr[i] = 16'($urandom);
            wd[i]   = 8'($urandom);
        end
        for (int k = 0; k < i; k++) begin
            chk("rdy_low_in_wait", i, {7'd0, rdy_s[i]}, 8'd0);
            @(posedge ph2);
            #1;
        end
        req[i] = 1'b0;
        chk("rdy_high_after_access", i, {7'd0, rdy_s[i]}, 8'd1);
        q = rd[i];
    endtask

    initial begin
        logic [7:0]  q, e;
        logic [15:0] a;
        logic        r;
        logic [7:0]  d;

        for (int i = 0; i < 4; i++) begin
            rst_b[i] = 1'b0;
            req[i]   = 1'b0;
            rw_s[i]  = 1'b1;
            addr[i]  = 16'h0000;
            wd[i]    = 8'h00;
            last[i]  = 8'h00;
        end

        tbl[0] = '{1'b0, 16'h0010, 8'hA9, 8'h00};
        tbl[1] = '{1'b1, 16'h0010, 8'h00, 8'hA9};
        tbl[2] = '{1'b1, 16'hFFFC, 8'h00, 8'h00};
        tbl[3] = '{1'b1, 16'hFFFD, 8'h00, 8'h02};
        tbl[4] = '{1'b0, 16'hFFFC, 8'hFF, 8'h02};
        tbl[5] = '{1'b1, 16'hFFFC, 8'h00, 8'h00};
        tbl[6] = '{1'b0, 16'h1123, 8'h55, 8'h00};
        tbl[7] = '{1'b1, 16'h0123, 8'h00, 8'h55};
        tbl[8] = '{1'b0, 16'h0FFF, 8'h3C, 8'h55};
        tbl[9] = '{1'b1, 16'hFFFF, 8'h00, 8'h3C};

        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_rdy", i, {7'd0, rdy_s[i]}, 8'd1);
            chk("reset_data_in", i, rd[i], 8'h00);
        end
        repeat (2) @(negedge ph2);
        for (int i = 0; i < 4; i++) rst_b[i] = 1'b1;

        // Table vectors, applied back-to-back on every instance.
        for (int i = 0; i < 4; i++) begin
            for (int t = 0; t < 10; t++) begin
                access(i, tbl[t].r, tbl[t].a, tbl[t].d, q);
                e = mdl_access(i, tbl[t].r, tbl[t].a, tbl[t].d);
                chk($sformatf("table[%0d]", t), i, q, tbl[t].exp);
            end
        end

        // Fill the low region used by the random traffic.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 16; k++) begin
                d = 8'($urandom);
                access(i, 1'b0, 16'(k), d, q);
                e = mdl_access(i, 1'b0, 16'(k), d);
            end
        end

        // W=2: read of 0x0000 holding 0x01.
        access(2, 1'b0, 16'h0000, 8'h01, q);
        e = mdl_access(2, 1'b0, 16'h0000, 8'h01);
        access(2, 1'b1, 16'h0000, 8'h00, q);
        e = mdl_access(2, 1'b1, 16'h0000, 8'h00);
        chk("w2_read_0000", 2, q, 8'h01);

        // W=1: bus changed while stalled must not affect the latched write.
        access(1, 1'b0, 16'h0005, 8'h9A, q);
        e = mdl_access(1, 1'b0, 16'h0005, 8'h9A);
        access(1, 1'b1, 16'h0005, 8'h00, q);
        e = mdl_access(1, 1'b1, 16'h0005, 8'h00);
        chk("w1_latched_write", 1, q, 8'h9A);
        access(1, 1'b1, 16'h0006, 8'h00, q);
        e = mdl_access(1, 1'b1, 16'h0006, 8'h00);
        chk("w1_neighbour_intact", 1, q, e);

        // W=3: reset during the second WAIT cycle aborts the write.
        access(3, 1'b0, 16'h0040, 8'h11, q);
        e = mdl_access(3, 1'b0, 16'h0040, 8'h11);
        access(3, 1'b1, 16'h0040, 8'h00, q);
        e = mdl_access(3, 1'b1, 16'h0040, 8'h00);
        chk("w3_pre_read", 3, q, 8'h11);
        @(negedge ph2);
        req[3] = 1'b1; rw_s[3] = 1'b0; addr[3] = 16'h0040; wd[3] = 8'h77;
        @(posedge ph2);
        #1;
        req[3] = 1'b0;
        chk("w3_rdy_low_wait1", 3, {7'd0, rdy_s[3]}, 8'd0);
        @(posedge ph2);
        #1;
        rst_b[3] = 1'b0;
        #1;
        chk("w3_async_rdy", 3, {7'd0, rdy_s[3]}, 8'd1);
        chk("w3_async_data_in", 3, rd[3], 8'h00);
        last[3] = 8'h00;
        repeat (2) @(negedge ph2);
        rst_b[3] = 1'b1;
        access(3, 1'b1, 16'h0040, 8'h00, q);
        e = mdl_access(3, 1'b1, 16'h0040, 8'h00);
        chk("w3_write_aborted", 3, q, 8'h11);

        // Randomized traffic against the model.
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 40; n++) begin
                int lo, hi, sel;
                lo  = $urandom_range(0, 15);
                hi  = $urandom_range(0, 15);
                sel = $urandom_range(0, 7);
                if (sel == 0)      a = 16'hFFFC;
                else if (sel == 1) a = 16'hFFFD;
                else               a = {hi[3:0], 8'h00, lo[3:0]};
                r = 1'($urandom);
                d = 8'($urandom);
                access(i, r, a, d, q);
                e = mdl_access(i, r, a, d);
                chk("random", i, q, e);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
